// File: rtl/fifo_sample_reader.sv
// Drains the sample FIFO at a programmable rate and hands each word downstream
// over valid/ready, counting sample slots that could not be served.
module fifo_sample_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  empty_i,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  clr_i,
  output logic                  underrun_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DIV_WIDTH-1:0]         cnt_q, cnt_d;
  logic [1:0]                   state_q, state_d;
  logic                         rd_en_q, rd_en_d;
  logic                         valid_q, valid_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0]         miss_cnt_q, miss_cnt_d;
  logic                         tick;
  logic                         miss;

  // Miss counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + CNT_ONE;
  endfunction

  always_comb begin
    tick = en_i && (cnt_q == div_i);

    cnt_d = cnt_q;
    if (!en_i || tick) cnt_d = '0;
    else               cnt_d = cnt_q + DIV_ONE;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tick && !empty_i) state_d = ST_READ;
      ST_READ: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_OUT;
      ST_OUT:  if (ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A tick is lost if a transfer is still in flight or there is nothing to read.
    miss = tick && ((state_q != ST_IDLE) || empty_i);

    rd_en_d = (state_d == ST_READ);
    valid_d = (state_d == ST_OUT);

    data_d = data_q;
    if (state_q == ST_LOAD) data_d = fifo_data_i;

    underrun_d = underrun_q;
    miss_cnt_d = miss_cnt_q;
    if (clr_i) begin
      underrun_d = miss;
      miss_cnt_d = miss ? CNT_ONE : '0;
    end else if (miss) begin
      underrun_d = 1'b1;
      miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      underrun_q <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign rd_en_o    = rd_en_q;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign underrun_o = underrun_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Bench for fifo_sample_reader: FIFO environment plus a timestamp-based
// reference model of tick acceptance, output timing and miss accounting.
module tb_fifo_sample_reader;
  localparam int DW = 16;
  localparam int VW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_i;
  logic [VW-1:0] div_i;
  logic          empty_i;
  logic          rd_en_o;
  logic [DW-1:0] fifo_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          clr_i;
  logic          underrun_o;
  logic [CW-1:0] miss_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_sample_reader #(.DATA_WIDTH(DW), .DIV_WIDTH(VW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .div_i(div_i), .empty_i(empty_i),
    .rd_en_o(rd_en_o), .fifo_data_i(fifo_data_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .clr_i(clr_i),
    .underrun_o(underrun_o), .miss_cnt_o(miss_cnt_o)
  );

  logic [DW-1:0] fq[$];
  logic [DW-1:0] seen[$];
  int            rd_seen;

  int            cyc;
  int            m_cnt;
  bit            m_pend;
  int            m_tacc;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_data;
  int            m_miss;
  bit            m_und;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_rd();
    return m_pend && (cyc == m_tacc + 1);
  endfunction

  function automatic bit m_vld();
    return m_pend && (cyc >= m_tacc + 3);
  endfunction

  task automatic model_reset();
    cyc = 0; m_cnt = 0; m_pend = 0; m_tacc = 0;
    m_word = '0; m_data = '0; m_miss = 0; m_und = 0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    empty_i = 1'b0;
  endtask

  task automatic step();
    bit rd_now, tick, miss, hs;
    chk("rd_en_o",    32'(rd_en_o),    32'(m_rd()));
    chk("valid_o",    32'(valid_o),    32'(m_vld()));
    chk("data_o",     32'(data_o),     32'(m_data));
    chk("underrun_o", 32'(underrun_o), 32'(m_und));
    chk("miss_cnt_o", 32'(miss_cnt_o), 32'(m_miss));
    if (valid_o && ready_i) seen.push_back(data_o);
    if (rd_en_o) rd_seen++;
    tick = en_i && (m_cnt == int'(div_i));
    hs   = m_vld() && ready_i;
    miss = tick && (m_pend || fq.size() == 0);
    if (tick && !miss) begin
      m_pend = 1; m_tacc = cyc; m_word = fq[0];
    end else if (hs) begin
      m_pend = 0;
    end
    m_cnt = (!en_i || tick) ? 0 : (m_cnt + 1) % 65536;
    if (clr_i) begin
      m_miss = miss ? 1 : 0; m_und = miss;
    end else if (miss) begin
      m_und = 1;
      if (m_miss < 255) m_miss++;
    end
    rd_now = rd_en_o;
    @(posedge clk);
    #1;
    if (rd_now) begin
      if (fq.size() > 0) fifo_data_i = fq.pop_front();
      empty_i = (fq.size() == 0);
    end
    cyc++;
    if (m_pend && cyc == m_tacc + 3) m_data = m_word;
    @(negedge clk);
  endtask

  initial begin
    int w;
    int first;
    rst = 1'b0; en_i = 1'b0; div_i = 16'd3; empty_i = 1'b1;
    ready_i = 1'b1; clr_i = 1'b0; fifo_data_i = '0;
    #1;
    chk("rst_rd_en",    32'(rd_en_o),    32'd0);
    chk("rst_valid",    32'(valid_o),    32'd0);
    chk("rst_data",     32'(data_o),     32'd0);
    chk("rst_underrun", 32'(underrun_o), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Three words at period 4, then the FIFO runs dry.
    push(16'h0010); push(16'h0020); push(16'h0030);
    seen.delete(); rd_seen = 0;
    en_i = 1'b1; div_i = 16'd3;
    repeat (20) step();
    chk("t1_rd_count", 32'(rd_seen), 32'd3);
    chk("t1_n_out", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (seen.size() > i) chk("t1_data", 32'(seen[i]), 32'((i + 1) * 16));
    chk("t1_miss_cnt", 32'(miss_cnt_o), 32'd2);
    en_i = 1'b0; clr_i = 1'b1; step(); clr_i = 1'b0; step();

    // Empty FIFO for three ticks.
    div_i = 16'd4; en_i = 1'b1; rd_seen = 0;
    repeat (15) step();
    en_i = 1'b0;
    chk("t2_miss_cnt", 32'(miss_cnt_o), 32'd3);
    chk("t2_underrun", 32'(underrun_o), 32'd1);
    chk("t2_rd_count", 32'(rd_seen), 32'd0);
    clr_i = 1'b1; step(); clr_i = 1'b0;

    // Downstream stall for 16 clocks from the first valid.
    push(16'h1234); push(16'h8001);
    seen.delete(); div_i = 16'd3; en_i = 1'b1; ready_i = 1'b0;
    w = 0;
    while (!valid_o && w < 40) begin step(); w++; end
    chk("t3_valid_reached", 32'(valid_o), 32'd1);
    repeat (16) step();
    chk("t3_valid_held", 32'(valid_o), 32'd1);
    chk("t3_data_held", 32'(data_o), 32'h1234);
    chk("t3_miss_cnt", 32'(miss_cnt_o), 32'd4);
    ready_i = 1'b1;
    step();
    repeat (8) step();
    chk("t3_n_out", 32'(seen.size()), 32'd2);
    if (seen.size() > 1) chk("t3_second", 32'(seen[1]), 32'h8001);

    // Saturation and clear behaviour.
    en_i = 1'b0; clr_i = 1'b1; step(); clr_i = 1'b0;
    div_i = 16'd0; en_i = 1'b1;
    repeat (300) step();
    en_i = 1'b0;
    chk("t4_saturated", 32'(miss_cnt_o), 32'd255);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    chk("t4_clr_cnt", 32'(miss_cnt_o), 32'd0);
    chk("t4_clr_underrun", 32'(underrun_o), 32'd0);
    en_i = 1'b1; clr_i = 1'b1; step(); en_i = 1'b0; clr_i = 1'b0;
    chk("t4_clr_and_miss", 32'(miss_cnt_o), 32'd1);
    chk("t4_clr_and_miss_und", 32'(underrun_o), 32'd1);
    clr_i = 1'b1; step(); clr_i = 1'b0;

    // Asynchronous reset while the word is being loaded.
    push(16'h00AA); push(16'h00BB); push(16'h00CC);
    div_i = 16'd3; en_i = 1'b1;
    w = 0;
    while (!rd_en_o && w < 40) begin step(); w++; end
    chk("t5_rd_reached", 32'(rd_en_o), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("t5_rd_en",    32'(rd_en_o),    32'd0);
    chk("t5_valid",    32'(valid_o),    32'd0);
    chk("t5_data",     32'(data_o),     32'd0);
    chk("t5_underrun", 32'(underrun_o), 32'd0);
    chk("t5_miss_cnt", 32'(miss_cnt_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      if (rd_en_o && first < 0) first = k;
      step();
    end
    chk("t5_first_rd", 32'(first), 32'd4);

    // Enable dropped during the read cycle.
    en_i = 1'b0;
    repeat (6) step();
    push(16'h7FFF); push(16'h0042);
    en_i = 1'b1;
    w = 0;
    while (!rd_en_o && w < 40) begin step(); w++; end
    chk("t6_rd_reached", 32'(rd_en_o), 32'd1);
    en_i = 1'b0;
    step(); step();
    chk("t6_valid", 32'(valid_o), 32'd1);
    chk("t6_data", 32'(data_o), 32'h7FFF);
    rd_seen = 0;
    repeat (10) step();
    chk("t6_no_rd", 32'(rd_seen), 32'd0);
    chk("t6_valid_done", 32'(valid_o), 32'd0);

    // Randomized traffic against the reference model.
    for (int blk = 0; blk < 12; blk++) begin
      en_i = 1'b0;
      div_i = VW'($urandom_range(0, 5));
      step();
      for (int i = 0; i < 32; i++) begin
        en_i    = ($urandom_range(0, 9) != 0);
        ready_i = ($urandom_range(0, 3) != 0);
        clr_i   = ($urandom_range(0, 19) == 0);
        if (fq.size() < 4 && $urandom_range(0, 2) == 0) push(DW'($urandom));
        step();
      end
    end
    clr_i = 1'b0; ready_i = 1'b1; en_i = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
